store_unit: RTL

STORE_UNIT -- requirements
Module: store_unit

---
 rtl/store_unit_pkg.sv | 36 +++
 rtl/store_unit_lane.sv | 44 ++++
 rtl/store_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/store_unit_pkg.sv
// Shared codes for the load/store path: access size codes, store FSM
// state encodings and the byte-lane merge helpers.
package store_unit_pkg;

  // Access size codes (2'b11 is reserved and behaves as a word access)
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Store FSM state encodings
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RD_REQ  = 2'b01;
  localparam logic [1:0] ST_RD_WAIT = 2'b10;
  localparam logic [1:0] ST_WR_REQ  = 2'b11;

  // Expand each byte-enable bit into a full 8-bit lane mask.
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] mask;
    mask = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      mask[i*8 +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

  // Merge new lane data into an existing memory word under the byte enables.
  function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                             input logic [31:0] lane_data,
                                             input logic [3:0]  be);
    logic [31:0] mask;
    mask = be_to_mask(be);
    return (old_word & ~mask) | (lane_data & mask);
  endfunction

endpackage

// File: rtl/store_unit_lane.sv
// Combinational byte-lane generation for stores: byte enables, lane-
// replicated data and alignment fault detection from address low bits and size.
module store_lane
  import store_unit_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_lanedata,
  output logic        o_misaligned
);

  // Decode size into byte enables, replicated lane data and misalignment
  always_comb begin
    o_be         = 4'b0000;
    o_lanedata   = 32'h0000_0000;
    o_misaligned = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        o_be         = 4'b0001 << i_addr_lo;
        o_lanedata   = {4{i_data[7:0]}};
        o_misaligned = 1'b0;
      end
      SZ_HALF: begin
        o_be         = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_lanedata   = {2{i_data[15:0]}};
        o_misaligned = i_addr_lo[0];
      end
      SZ_WORD: begin
        o_be         = 4'b1111;
        o_lanedata   = i_data;
        o_misaligned = (i_addr_lo != 2'b00);
      end
      default: begin
        // reserved code behaves as a word store
        o_be         = 4'b1111;
        o_lanedata   = i_data;
        o_misaligned = (i_addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts byte/half/word stores, performs read-modify-write for
// sub-word stores against a word-wide memory, and faults misaligned accesses.
module store_unit
  import store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        st_done,
  output logic        st_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [3:0]  w_be;
  logic [31:0] w_lanedata;
  logic        w_misaligned;
  logic        w_accept;
  logic        w_is_word;
  logic        w_start;
  logic        w_fault;
  logic [31:0] w_merged;

  logic        r_st_ready;
  logic        r_st_done;
  logic        r_st_fault;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic [31:0] r_lanedata;

  store_lane u_lane (
    .i_addr_lo    (st_addr[1:0]),
    .i_size       (st_size),
    .i_data       (st_data),
    .o_be         (w_be),
    .o_lanedata   (w_lanedata),
    .o_misaligned (w_misaligned)
  );

  // r_st_ready is only high in IDLE; the state term guards against a corrupted ready flop
  assign w_accept  = st_valid && r_st_ready && (r_state == ST_IDLE);
  assign w_is_word = (st_size == SZ_WORD) || (st_size == SZ_RSVD);
  assign w_start   = w_accept && !w_misaligned;
  assign w_fault   = w_accept && w_misaligned;
  assign w_merged  = merge_word(mem_rdata, r_lanedata, r_mem_be);

  // Next-state decode; grants and read data are only honoured in their own states
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          if (w_is_word) begin
            w_state_nxt = ST_WR_REQ;
          end else begin
            w_state_nxt = ST_RD_REQ;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        if (mem_gnt) begin
          w_state_nxt = ST_RD_WAIT;
        end else begin
          w_state_nxt = ST_RD_REQ;
        end
      end
      ST_RD_WAIT: begin
        if (mem_rvalid) begin
          w_state_nxt = ST_WR_REQ;
        end else begin
          w_state_nxt = ST_RD_WAIT;
        end
      end
      ST_WR_REQ: begin
        if (mem_gnt) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WR_REQ;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Control outputs registered from the next state so they align with r_state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st_ready <= 1'b1;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
    end else begin
      r_st_ready <= (w_state_nxt == ST_IDLE);
      r_mem_req  <= (w_state_nxt == ST_RD_REQ) || (w_state_nxt == ST_WR_REQ);
      r_mem_we   <= (w_state_nxt == ST_WR_REQ);
    end
  end

  // Completion pulses: fault the cycle after a misaligned accept, done after write grant
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st_done  <= 1'b0;
      r_st_fault <= 1'b0;
    end else begin
      r_st_done  <= w_fault || ((r_state == ST_WR_REQ) && mem_gnt);
      r_st_fault <= w_fault;
    end
  end

  // Address, byte enables and lane data captured at acceptance, held for the whole store
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_addr <= 32'h0000_0000;
      r_mem_be   <= 4'b0000;
      r_lanedata <= 32'h0000_0000;
    end else if (w_start) begin
      r_mem_addr <= {st_addr[31:2], 2'b00};
      r_mem_be   <= w_be;
      r_lanedata <= w_lanedata;
    end else begin
      r_mem_addr <= r_mem_addr;
      r_mem_be   <= r_mem_be;
      r_lanedata <= r_lanedata;
    end
  end

  // Write word: direct data for word stores, merged read data for sub-word stores
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_wdata <= 32'h0000_0000;
    end else if (w_start && w_is_word) begin
      r_mem_wdata <= w_lanedata;
    end else if ((r_state == ST_RD_WAIT) && mem_rvalid) begin
      r_mem_wdata <= w_merged;
    end else begin
      r_mem_wdata <= r_mem_wdata;
    end
  end

  assign st_ready  = r_st_ready;
  assign st_done   = r_st_done;
  assign st_fault  = r_st_fault;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;

endmodule
